// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants for the round-robin mux arbiter.
// Key width helper and EMPTY/FULL state encoding.
package mux_rr_arbiter_pkg;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // ceil(log2(n)), at least 1
  function automatic int sel_len(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mux_key_lut.sv
// Parameterized key/lut mux.
// Returns the lut entry whose index equals key.
module mux_key_lut #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 2
) (
  input  logic [KEY_LEN-1:0]         key,
  input  logic [NR_KEY*DATA_LEN-1:0] lut,
  output logic [DATA_LEN-1:0]        out
);

  // match key against every entry index
  always_comb begin
    out = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (key == KEY_LEN'(i))
        out = lut[i*DATA_LEN +: DATA_LEN];
    end
  end

endmodule

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Round-robin pick: rotate req by ptr,
// fixed-priority find-first, rotate back.
import mux_rr_arbiter_pkg::*;

module mux_rr_arbiter_rr_pick #(
  parameter int NR_REQ  = 4,
  parameter int SEL_LEN = sel_len(NR_REQ)
) (
  input  logic [NR_REQ-1:0]  req,
  input  logic [SEL_LEN-1:0] ptr,
  output logic [SEL_LEN-1:0] pick,
  output logic               any
);

  logic [2*NR_REQ-1:0] w_dbl;
  logic [NR_REQ-1:0]   w_rot;
  logic [SEL_LEN-1:0]  w_idx;

  assign w_dbl = {req, req} >> ptr;
  assign w_rot = w_dbl[NR_REQ-1:0];
  assign any   = |req;

  // lowest set bit of the rotated vector wins
  always_comb begin
    w_idx = '0;
    for (int i = NR_REQ - 1; i >= 0; i--) begin
      if (w_rot[i])
        w_idx = SEL_LEN'(i);
    end
  end

  assign pick = w_idx + ptr;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter in front of a shared key/lut mux,
// one output register with valid/ready handshake.
import mux_rr_arbiter_pkg::*;

module mux_rr_arbiter #(
  parameter int NR_REQ   = 4,
  parameter int DATA_LEN = 2,
  parameter int SEL_LEN  = sel_len(NR_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NR_REQ-1:0]          req,
  input  logic [NR_REQ*DATA_LEN-1:0] data,
  output logic [NR_REQ-1:0]          gnt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_LEN-1:0]        out_data,
  output logic [SEL_LEN-1:0]         out_sel,
  output logic                       busy
);

  logic [0:0]          r_state;
  logic [SEL_LEN-1:0]  r_ptr;
  logic [DATA_LEN-1:0] r_data;
  logic [SEL_LEN-1:0]  r_sel;

  logic [SEL_LEN-1:0]  w_pick;
  logic                w_any;
  logic [DATA_LEN-1:0] w_mux;
  logic                w_valid;
  logic                w_free;
  logic                w_grant;

  mux_rr_arbiter_rr_pick #(
    .NR_REQ  (NR_REQ),
    .SEL_LEN (SEL_LEN)
  ) u_pick (
    .req  (req),
    .ptr  (r_ptr),
    .pick (w_pick),
    .any  (w_any)
  );

  mux_key_lut #(
    .NR_KEY   (NR_REQ),
    .KEY_LEN  (SEL_LEN),
    .DATA_LEN (DATA_LEN)
  ) u_mux (
    .key (w_pick),
    .lut (data),
    .out (w_mux)
  );

  assign w_valid = (r_state == ST_FULL);
  assign w_free  = !w_valid | out_ready;
  // no grant can be issued while held in reset
  assign w_grant = w_free & w_any & rst_n;

  assign gnt = w_grant ?
    (NR_REQ'(1) << w_pick) : '0;

  assign out_valid = w_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign busy      = w_valid | (|req);

  // pointer, output register and EMPTY/FULL state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_ptr   <= '0;
      r_data  <= '0;
      r_sel   <= '0;
    end else if (w_grant) begin
      r_state <= ST_FULL;
      r_ptr   <= w_pick + 1'b1;
      r_data  <= w_mux;
      r_sel   <= w_pick;
    end else if (w_valid & out_ready) begin
      r_state <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter.
// Hand-computed expectations, immediate assertions.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] data;
  logic [3:0] gnt;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_data;
  logic [1:0] out_sel;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  mux_rr_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data      (data),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag,
                         input logic v,
                         input logic [1:0] d,
                         input logic [1:0] s);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_data"},  32'(out_data),  32'(d));
    chk({tag, "_sel"},   32'(out_sel),   32'(s));
  endtask

  logic [3:0] rr_gnt [5];
  logic [1:0] rr_idx [5];

  initial begin
    rr_gnt = '{4'b0001, 4'b0010, 4'b0100,
               4'b1000, 4'b0001};
    rr_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    rst_n     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    data      = {2'd3, 2'd2, 2'd1, 2'd0};
    #2;
    chk_out("reset", 1'b0, 2'd0, 2'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    req = 4'b1111;
    #1;
    chk("reset_gnt", 32'(gnt), 32'd0);
    req = 4'b0000;
    tick();
    rst_n = 1'b1;

    // round robin, all requesting
    tick();
    req       = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_gnt", 32'(gnt), 32'(rr_gnt[k]));
      tick();
      chk_out("rr", 1'b1, rr_idx[k], rr_idx[k]);
    end
    req = 4'b0000;
    tick();
    chk_out("rr_drain", 1'b0, 2'd0, 2'd0);

    // stall with requester 1 (ptr = 1)
    out_ready = 1'b0;
    req       = 4'b0010;
    #1;
    chk("st_gnt0", 32'(gnt), 32'b0010);
    tick();
    chk_out("st_load", 1'b1, 2'd1, 2'd1);
    for (int k = 0; k < 5; k++) begin
      chk("st_gnt", 32'(gnt), 32'd0);
      tick();
      chk_out("st_hold", 1'b1, 2'd1, 2'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("st_accgnt", 32'(gnt), 32'b0010);
    tick();
    chk_out("st_refill", 1'b1, 2'd1, 2'd1);
    req = 4'b0000;
    tick();
    chk_out("st_drain", 1'b0, 2'd1, 2'd1);

    // wrap: grant 2 -> ptr 3, then 3 before 0
    req = 4'b0100;
    #1;
    chk("wr_gnt2", 32'(gnt), 32'b0100);
    tick();
    chk_out("wr_2", 1'b1, 2'd2, 2'd2);
    req = 4'b1001;
    #1;
    chk("wr_gnt3", 32'(gnt), 32'b1000);
    tick();
    chk_out("wr_3", 1'b1, 2'd3, 2'd3);
    #1;
    chk("wr_gnt0", 32'(gnt), 32'b0001);
    tick();
    chk_out("wr_0", 1'b1, 2'd0, 2'd0);
    req = 4'b0000;
    tick();
    chk_out("wr_drain", 1'b0, 2'd0, 2'd0);

    // withdrawn request while stalled
    out_ready = 1'b0;
    req       = 4'b0001;
    #1;
    chk("wd_gnt0", 32'(gnt), 32'b0001);
    tick();
    chk_out("wd_full", 1'b1, 2'd0, 2'd0);
    req = 4'b0100;
    #1;
    chk("wd_stall", 32'(gnt), 32'd0);
    tick();
    req = 4'b0000;
    #1;
    chk("wd_drop", 32'(gnt), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("wd_acc", 32'(gnt), 32'd0);
    tick();
    chk_out("wd_empty", 1'b0, 2'd0, 2'd0);
    chk("wd_busy", 32'(busy), 32'd0);

    // single continuous requester 0
    req = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      data = {2'd3, 2'd2, 2'd1, 2'(k)};
      #1;
      chk("sg_gnt", 32'(gnt), 32'b0001);
      tick();
      chk_out("sg", 1'b1, 2'(k), 2'd0);
    end

    // asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("ar", 1'b0, 2'd0, 2'd0);
    chk("ar_gnt", 32'(gnt), 32'd0);
    tick();
    req = 4'b0000;
    #2;
    rst_n = 1'b1;
    tick();
    data = {2'd3, 2'd2, 2'd1, 2'd0};
    req  = 4'b0100;
    #1;
    chk("ar_gnt2", 32'(gnt), 32'b0100);
    tick();
    chk_out("ar_2", 1'b1, 2'd2, 2'd2);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Shares one NR_REQ:1 key-select mux datapath between NR_REQ requesters, each offering a DATA_LEN-bit word.
- Round-robin arbitration picks one requester and drives the mux key; the selected word is captured into a single output register.
- Output side uses a valid/ready handshake. The block sits in front of any consumer that needs one serialized stream from four mux sources.

Parameters:
- NR_REQ, 4, number of requesters and mux inputs; power of two, ≥2.
- DATA_LEN, 2, width of each requester word and of out_data.
- SEL_LEN, 2, width of the mux key / out_sel; must equal log2(NR_REQ).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NR_REQ  per-requester request; bit i belongs to requester i.
- data  input  NR_REQ*DATA_LEN  flat words; requester i at bits [i*DATA_LEN +: DATA_LEN].
- gnt  output  NR_REQ  one-hot grant pulse, combinational; at most one bit set.
- out_valid  output  1  output register holds an unconsumed word.
- out_ready  input  1  consumer accepts when out_valid & out_ready.
- out_data  output  DATA_LEN  captured word.
- out_sel  output  SEL_LEN  index of the requester that produced out_data.
- busy  output  1  out_valid | (|req).

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0. gnt=0 while in reset. Any held word is discarded and no grant is issued for it.
- Slot free: slot_free = !out_valid | out_ready. An accept, a refill and a grant may all occur in the same cycle.
- Arbitration: when slot_free & (|req), pick the first i with req[i]=1, scanning ptr, ptr+1, ... mod NR_REQ. Mux key = pick.
- Grant: gnt[pick]=1 in that same cycle only.
- Registers on that edge: out_data <= data[pick], out_sel <= pick, out_valid <= 1, ptr <= (pick+1) mod NR_REQ with natural SEL_LEN wrap.
- Accept with no new grant: out_valid & out_ready & !(|req) gives out_valid <= 0. out_data and out_sel hold their last values.
- Stall: out_valid & !out_ready gives gnt=0, and out_data, out_sel, out_valid and ptr all hold.
- Latency: req to out_valid is 1 cycle. Throughput is 1 word per cycle while out_ready=1 and requests are present.
- Requester contract: keep req and data stable until gnt is seen. gnt is a single-cycle pulse; the requester may re-raise req the next cycle for a new word. Dropping req before gnt is legal and withdraws the request with no grant.
- Fairness: a requester holding req is granted within NR_REQ grants. After granting i, requester i has the lowest priority.
- Wrap-around: pick = NR_REQ-1 sets ptr to 0.
- Single requester: a lone continuous requester is granted every free cycle.
- Internal FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY → FULL on a grant.
  - FULL → FULL on accept+grant or on stall.
  - FULL → EMPTY on accept with no req.
- No X propagation: out_data is only loaded from a granted input.

Decomposition:
- Shared package: SEL_LEN derivation (log2 of NR_REQ) and the EMPTY/FULL state encoding constants.
- One natural sub-module: rr_pick. Combinational; inputs req and ptr, outputs pick and any. Implemented as a rotate, fixed-priority find-first, then rotate back.
- Data selection reuses the team's existing parameterized key/lut mux. The top builds the lut from data with key = pick.
- Pointer, output register and FSM live in mux_rr_arbiter itself.

Test Plan:
- Reset mid-operation: FULL with out_data=2'b11; assert rst_n=0 asynchronously between edges → out_valid=0, out_data=0, out_sel=0 immediately. After release, req=4'b0100 grants index 2 first.
- Round robin: req=4'b1111 held, data={X3=3,X2=2,X1=1,X0=0}, out_ready=1 → out_sel sequence 0,1,2,3,0; gnt one-hot each cycle.
- Stall: out_ready=0 with req=4'b0010 → exactly one gnt[1] pulse; out_data=X1 held for 5 cycles. Raise out_ready → accepted, then next grant in the same cycle.
- Wrap and priority: ptr=3 (after granting 2), req=4'b1001 → grant 3, then 0.
- Withdrawn request: req[2] raised, out_valid=1 & out_ready=0, req[2] dropped before slot frees → no gnt[2]. out_valid clears after accept.
- Single requester: req=4'b0001 continuous with out_ready=1 → gnt[0]=1 every cycle, out_valid stays 1, out_data tracks X0 with 1-cycle delay.
